id_hazard_scoreboard: RTL and testbench

//  Decode-stage operand/hazard unit. Generalises the fixed two-stage forwarding and one-bubble load-use stall to
//  NRD read ports and NSTAGE forwarding stages. A per-register scoreboard of countdown counters covers loads of

---
 rtl/id_hazard_scoreboard.sv | 94 +++++++++
 tb/tb_id_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: decode-stage operand forwarding and load-use hazard scoreboard
module id_hazard_scoreboard #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NSTAGE   = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                issue_i,
    input  logic                issue_wreg_i,
    input  logic [AW-1:0]       issue_wd_i,
    input  logic                issue_load_i,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    input  logic [NRD*DW-1:0]   rf_data_i,
    input  logic [NSTAGE-1:0]   fwd_wreg_i,
    input  logic [NSTAGE*AW-1:0] fwd_wd_i,
    input  logic [NSTAGE*DW-1:0] fwd_wdata_i,
    output logic [NRD*DW-1:0]   rd_data_o,
    output logic                stallreq_o,
    output logic                pending_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);
    localparam int NREG = 2 ** AW;
    localparam int CW   = $clog2(LOAD_LAT + 1);

    logic [CW-1:0]    cnt_q [NREG];
    logic [CW-1:0]    cnt_d [NREG];
    logic [CNT_W-1:0] stall_cnt_q;
    logic             accept;
    logic             load_set;

    assign accept      = issue_i & ~stall_i & ~flush_i & ~stallreq_o;
    assign load_set    = accept & issue_wreg_i & issue_load_i & (issue_wd_i != '0);
    assign stall_cnt_o = stall_cnt_q;

    // A read port hazards when it reads a nonzero register whose load is still counting down
    always_comb begin
        stallreq_o = 1'b0;
        for (int p = 0; p < NRD; p++)
            stallreq_o |= rd_en_i[p] && (rd_addr_i[p*AW +: AW] != '0) && (cnt_q[rd_addr_i[p*AW +: AW]] != '0);
    end

    // Operand select: r0/disabled read zero, else youngest matching forward stage, else regfile
    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_en_i[p] && rd_addr_i[p*AW +: AW] != '0) begin
                rd_data_o[p*DW +: DW] = rf_data_i[p*DW +: DW];
                for (int s = NSTAGE - 1; s >= 0; s--)
                    if (fwd_wreg_i[s] && fwd_wd_i[s*AW +: AW] == rd_addr_i[p*AW +: AW])
                        rd_data_o[p*DW +: DW] = fwd_wdata_i[s*DW +: DW];
            end
        end
    end

    // Any register still waiting on a load
    always_comb begin
        pending_o = 1'b0;
        for (int r = 0; r < NREG; r++)
            pending_o |= (cnt_q[r] != '0);
    end

    // Countdown of every pending register; a newly accepted load reloads its destination
    always_comb begin
        for (int r = 0; r < NREG; r++)
            cnt_d[r] = (r != 0 && cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
        if (load_set)
            cnt_d[issue_wd_i] = CW'(LOAD_LAT);
    end

    // Scoreboard state: reset/flush drop everything, a frozen pipeline holds it
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
        end else if (!stall_i) begin
            cnt_q <= cnt_d;
        end
    end

    // Saturating count of cycles spent requesting a load-use stall
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stallreq_o && !flush_i && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: two scoreboards (load latency 1 and 2) driven by shared directed vectors
module tb_id_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i, flush_i, issue_i, issue_wreg_i, issue_load_i;
    logic [4:0]  issue_wd_i;
    logic [2:0]  rd_en_i;
    logic [14:0] rd_addr_i;
    logic [95:0] rf_data_i;
    logic [1:0]  fwd_wreg_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic [95:0] rd_a, rd_b;
    logic        st_a, st_b, pd_a, pd_b;
    logic [3:0]  sc_a;
    logic [31:0] sc_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.DW(32), .AW(5), .NRD(3), .NSTAGE(2), .LOAD_LAT(1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .issue_i(issue_i),
        .issue_wreg_i(issue_wreg_i), .issue_wd_i(issue_wd_i), .issue_load_i(issue_load_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rf_data_i(rf_data_i), .fwd_wreg_i(fwd_wreg_i),
        .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .rd_data_o(rd_a), .stallreq_o(st_a),
        .pending_o(pd_a), .stall_cnt_o(sc_a));

    id_hazard_scoreboard #(.DW(32), .AW(5), .NRD(3), .NSTAGE(2), .LOAD_LAT(2), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .issue_i(issue_i),
        .issue_wreg_i(issue_wreg_i), .issue_wd_i(issue_wd_i), .issue_load_i(issue_load_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rf_data_i(rf_data_i), .fwd_wreg_i(fwd_wreg_i),
        .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .rd_data_o(rd_b), .stallreq_o(st_b),
        .pending_o(pd_b), .stall_cnt_o(sc_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles per register and stall count, per instance
    int     rem [2][32];
    longint msc [2];
    bit     live = 1'b0;
    bit     hz_m [2];

    function automatic bit m_stall(input int i);
        for (int p = 0; p < 3; p++)
            if (rd_en_i[p] && rd_addr_i[p*5 +: 5] != 0 && rem[i][rd_addr_i[p*5 +: 5]] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_pend(input int i);
        for (int r = 0; r < 32; r++)
            if (rem[i][r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_op(input int p);
        logic [4:0] a;
        a = rd_addr_i[p*5 +: 5];
        if (!rd_en_i[p] || a == 0) return 32'h0;
        for (int s = 0; s < 2; s++)
            if (fwd_wreg_i[s] && fwd_wd_i[s*5 +: 5] == a) return fwd_wdata_i[s*32 +: 32];
        return rf_data_i[p*32 +: 32];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) hz_m[i] = m_stall(i);
        for (int i = 0; i < 2; i++) begin
            if (rst || flush_i) begin
                for (int r = 0; r < 32; r++) rem[i][r] = 0;
            end else if (!stall_i) begin
                for (int r = 0; r < 32; r++) if (rem[i][r] > 0) rem[i][r] = rem[i][r] - 1;
                if (issue_i && !hz_m[i] && issue_wreg_i && issue_load_i && issue_wd_i != 0)
                    rem[i][issue_wd_i] = i + 1;
            end
            if (rst) msc[i] = 0;
            else if (hz_m[i] && !flush_i && msc[i] < (i == 0 ? 64'd15 : 64'hFFFF_FFFF)) msc[i] = msc[i] + 1;
        end
        if (rst) live = 1'b1;
    end

    // Every-cycle comparison against the model; operands only when no hazard is expected
    always @(negedge clk) begin
        if (live) begin
            chk("m_stall_a", {63'b0, st_a}, {63'b0, m_stall(0)});
            chk("m_stall_b", {63'b0, st_b}, {63'b0, m_stall(1)});
            chk("m_pend_a", {63'b0, pd_a}, {63'b0, m_pend(0)});
            chk("m_pend_b", {63'b0, pd_b}, {63'b0, m_pend(1)});
            chk("m_cnt_a", {60'b0, sc_a}, msc[0]);
            chk("m_cnt_b", {32'b0, sc_b}, msc[1]);
            for (int p = 0; p < 3; p++) begin
                if (!m_stall(0)) chk($sformatf("m_op_a%0d", p), {32'b0, rd_a[p*32 +: 32]}, {32'b0, m_op(p)});
                if (!m_stall(1)) chk($sformatf("m_op_b%0d", p), {32'b0, rd_b[p*32 +: 32]}, {32'b0, m_op(p)});
            end
        end
    end

    task automatic idle;
        stall_i = 0; flush_i = 0; issue_i = 0; issue_wreg_i = 0; issue_load_i = 0; issue_wd_i = 0;
        rd_en_i = 0; rd_addr_i = 0; rf_data_i = 0; fwd_wreg_i = 0; fwd_wd_i = 0; fwd_wdata_i = 0;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    task automatic ld(input logic [4:0] wd);
        issue_i = 1; issue_wreg_i = 1; issue_load_i = 1; issue_wd_i = wd;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en_i[p] = 1'b1;
        rd_addr_i[p*5 +: 5] = a;
    endtask

    task automatic fwd(input int s, input logic [4:0] wd, input logic [31:0] d);
        fwd_wreg_i[s] = 1'b1;
        fwd_wd_i[s*5 +: 5] = wd;
        fwd_wdata_i[s*32 +: 32] = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {63'b0, st_a}, 0);
        chk("rst_pend", {63'b0, pd_a}, 0);
        chk("rst_cnt_a", {60'b0, sc_a}, 0);
        chk("rst_cnt_b", {32'b0, sc_b}, 0);

        nxt(); ld(5);
        nxt(); issue_i = 1; rd(0, 5);
        @(negedge clk);
        chk("t1_stall_a", {63'b0, st_a}, 1);
        chk("t1_stall_b", {63'b0, st_b}, 1);
        chk("t1_pend_a", {63'b0, pd_a}, 1);
        nxt(); issue_i = 1; rd(0, 5); fwd(1, 5, 32'h12345678);
        @(negedge clk);
        chk("t1_release_a", {63'b0, st_a}, 0);
        chk("t1_fwd_a", {32'b0, rd_a[31:0]}, 64'h12345678);
        chk("t1_still_b", {63'b0, st_b}, 1);
        nxt(); issue_i = 1; rd(0, 5); fwd(1, 5, 32'h12345678);
        @(negedge clk);
        chk("t1_release_b", {63'b0, st_b}, 0);
        chk("t1_fwd_b", {32'b0, rd_b[31:0]}, 64'h12345678);
        chk("t1_cnt_a", {60'b0, sc_a}, 1);
        chk("t1_cnt_b", {32'b0, sc_b}, 2);

        nxt(); ld(5);
        repeat (3) begin
            nxt(); stall_i = 1; issue_i = 1; rd(0, 5);
        end
        @(negedge clk);
        chk("t2_hold_pend_b", {63'b0, pd_b}, 1);
        nxt(); issue_i = 1; rd(0, 5);
        @(negedge clk);
        chk("t2_s1_a", {63'b0, st_a}, 1);
        chk("t2_s1_b", {63'b0, st_b}, 1);
        nxt(); issue_i = 1; rd(0, 5);
        @(negedge clk);
        chk("t2_s2_a", {63'b0, st_a}, 0);
        chk("t2_s2_b", {63'b0, st_b}, 1);
        nxt(); issue_i = 1; rd(0, 5);
        @(negedge clk);
        chk("t2_s3_b", {63'b0, st_b}, 0);
        chk("t2_cnt_a", {60'b0, sc_a}, 5);
        chk("t2_cnt_b", {32'b0, sc_b}, 7);

        nxt(); rd(0, 7); rd(1, 7); rf_data_i[31:0] = 32'h77; rf_data_i[63:32] = 32'h88;
        fwd(0, 7, 32'hA); fwd(1, 7, 32'hB);
        @(negedge clk);
        chk("t3_both_p0", {32'b0, rd_a[31:0]}, 64'hA);
        chk("t3_both_p1", {32'b0, rd_a[63:32]}, 64'hA);
        chk("t3_off_p2", {32'b0, rd_a[95:64]}, 0);
        nxt(); rd(0, 7); rf_data_i[31:0] = 32'h77; fwd(1, 7, 32'hB);
        @(negedge clk);
        chk("t3_old", {32'b0, rd_a[31:0]}, 64'hB);
        nxt(); rd(0, 7); rd(1, 7); rf_data_i[31:0] = 32'h77; rf_data_i[63:32] = 32'h88; fwd(0, 6, 32'hC);
        @(negedge clk);
        chk("t3_rf_p0", {32'b0, rd_a[31:0]}, 64'h77);
        chk("t3_rf_p1", {32'b0, rd_a[63:32]}, 64'h88);

        nxt(); ld(0);
        nxt(); issue_i = 1; rd(0, 0); fwd(0, 0, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t4_r0_data", {32'b0, rd_a[31:0]}, 0);
        chk("t4_r0_stall", {63'b0, st_a}, 0);
        chk("t4_r0_pend_a", {63'b0, pd_a}, 0);
        chk("t4_r0_pend_b", {63'b0, pd_b}, 0);

        nxt(); ld(9);
        nxt(); issue_i = 1; rd(0, 9); rd(1, 3); rd(2, 9); flush_i = 1;
        @(negedge clk);
        chk("t5_stall_a", {63'b0, st_a}, 1);
        chk("t5_stall_b", {63'b0, st_b}, 1);
        nxt(); issue_i = 1; rd(0, 9); rd(1, 3); rd(2, 9);
        @(negedge clk);
        chk("t5_flush_st_a", {63'b0, st_a}, 0);
        chk("t5_flush_st_b", {63'b0, st_b}, 0);
        chk("t5_flush_pd_a", {63'b0, pd_a}, 0);
        chk("t5_flush_pd_b", {63'b0, pd_b}, 0);
        chk("t5_cnt_a", {60'b0, sc_a}, 5);
        chk("t5_cnt_b", {32'b0, sc_b}, 7);

        repeat (40) begin
            nxt(); ld(9); rd(0, 9);
        end
        @(negedge clk);
        chk("t6_sat_a", {60'b0, sc_a}, 15);
        nxt(); ld(9); rd(0, 9); rst = 1'b1;
        nxt(); ld(9); rd(0, 9);
        @(negedge clk);
        chk("t6_rst_cnt_a", {60'b0, sc_a}, 0);
        chk("t6_rst_cnt_b", {32'b0, sc_b}, 0);
        chk("t6_rst_stall", {63'b0, st_a}, 0);
        chk("t6_rst_pend", {63'b0, pd_b}, 0);
        nxt();
        nxt();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
